// File: rtl/tone_envelope_if.sv
// tone_envelope_if: tone, note strobe and envelope status signals between sequencer and envelope stage
interface tone_envelope_if #(parameter int ENV_BW = 8);
  logic tone_i;
  logic note_strb_i;
  logic rest_i;
  logic enable_i;
  logic sound_o;
  logic [ENV_BW-1:0] level_o;
  logic [2:0] state_o;
  modport master (output tone_i, note_strb_i, rest_i, enable_i, input sound_o, level_o, state_o);
  modport slave (input tone_i, note_strb_i, rest_i, enable_i, output sound_o, level_o, state_o);
endinterface

// File: rtl/tone_envelope.sv
// tone_envelope: ADSR envelope that gates the raw tone with a duty PWM of the envelope level
module tone_envelope #(
  parameter int ENV_BW = 8,
  parameter int ATTACK_STEP = 2400,
  parameter int DECAY_STEP = 4800,
  parameter int RELEASE_STEP = 1200,
  parameter int SUSTAIN_LEVEL = 160
) (
  input logic clk,
  input logic rst_n,
  tone_envelope_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, ATTACK = 3'd1, DECAY = 3'd2, SUSTAIN = 3'd3, RELEASE = 3'd4} state_t;
  localparam logic [ENV_BW-1:0] MAX = {ENV_BW{1'b1}};
  localparam logic [ENV_BW-1:0] SUS = SUSTAIN_LEVEL[ENV_BW-1:0];
  state_t state, state_d;
  logic [ENV_BW-1:0] level, level_d, duty;
  logic [31:0] presc, presc_d, len;
  logic step, clr, gate, sound;
  always_comb begin
    len = state == ATTACK ? ATTACK_STEP : state == DECAY ? DECAY_STEP : state == RELEASE ? RELEASE_STEP : 32'd0;
    step = (len != 32'd0) && (presc == len - 32'd1);
  end
  always_comb begin
    state_d = state;
    level_d = level;
    clr = 1'b0;
    if (!bus.enable_i && level == '0) state_d = IDLE;
    else if (!bus.enable_i && state != RELEASE) state_d = RELEASE;
    else if (bus.enable_i && bus.note_strb_i) begin
      clr = 1'b1;
      state_d = !bus.rest_i ? ATTACK : level != '0 ? RELEASE : IDLE;
    end else begin
      case (state)
        ATTACK: if (step) begin
          level_d = level == MAX ? MAX : level + 1'b1;
          if (level >= MAX - 1'b1) state_d = DECAY;
        end
        DECAY: begin
          if (level <= SUS) state_d = SUSTAIN;
          else if (step) level_d = level - 1'b1;
        end
        SUSTAIN: state_d = SUSTAIN;
        RELEASE: begin
          if (level == '0) state_d = IDLE;
          else if (step) begin
            level_d = level - 1'b1;
            if (level == 1) state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          level_d = '0;
        end
      endcase
    end
    presc_d = (clr || step || state_d != state || len == 32'd0) ? 32'd0 : presc + 32'd1;
  end
  assign gate = (level == MAX) || (duty < level);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      level <= '0;
      presc <= '0;
      duty <= '0;
      sound <= 1'b0;
    end else begin
      state <= state_d;
      level <= level_d;
      presc <= presc_d;
      duty <= duty + 1'b1;
      sound <= bus.tone_i & gate & bus.enable_i;
    end
  end
  assign bus.sound_o = sound;
  assign bus.level_o = level;
  assign bus.state_o = state;
endmodule

// File: tb/tb_tone_envelope.sv
// tb_tone_envelope: directed envelope, duty, rest, retrigger, priority and reset checks
module tb_tone_envelope;
  logic clk = 1'b0;
  logic rst_n;
  int errors = 0;
  int checks = 0;
  int dc = 0;
  int cnt;
  logic exp_s;
  tone_envelope_if #(.ENV_BW(4)) bus();
  tone_envelope #(.ENV_BW(4), .ATTACK_STEP(2), .DECAY_STEP(3), .RELEASE_STEP(1), .SUSTAIN_LEVEL(10))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    dc = !rst_n ? 0 : (dc + 1) % 16;
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
  task automatic strobe(input logic rest);
    bus.note_strb_i = 1'b1;
    bus.rest_i = rest;
    tick;
    bus.note_strb_i = 1'b0;
    bus.rest_i = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    bus.tone_i = 1'b1;
    bus.note_strb_i = 1'b0;
    bus.rest_i = 1'b0;
    bus.enable_i = 1'b1;
    tick;
    tick;
    chk("reset_state", bus.state_o, 0);
    chk("reset_level", bus.level_o, 0);
    chk("reset_sound", bus.sound_o, 0);
    rst_n = 1'b1;
    strobe(1'b0);
    chk("atk_enter_state", bus.state_o, 1);
    chk("atk_enter_level", bus.level_o, 0);
    repeat (29) tick;
    chk("atk_29_level", bus.level_o, 14);
    chk("atk_29_state", bus.state_o, 1);
    tick;
    chk("atk_max_level", bus.level_o, 15);
    chk("atk_max_state", bus.state_o, 2);
    cnt = 0;
    repeat (3) begin tick; cnt += int'(bus.sound_o); end
    chk("duty_max_full", cnt, 3);
    chk("decay_first_step", bus.level_o, 14);
    repeat (11) tick;
    chk("decay_11_level", bus.level_o, 11);
    tick;
    chk("decay_sus_level", bus.level_o, 10);
    chk("decay_sus_state", bus.state_o, 2);
    tick;
    chk("sustain_state", bus.state_o, 3);
    chk("sustain_level", bus.level_o, 10);
    cnt = 0;
    repeat (16) begin tick; cnt += int'(bus.sound_o); end
    chk("duty_10_of_16", cnt, 10);
    repeat (8) begin
      bus.tone_i = ~bus.tone_i;
      exp_s = bus.tone_i & (dc < 10);
      tick;
      chk("tone_follow", bus.sound_o, exp_s);
    end
    bus.tone_i = 1'b1;
    strobe(1'b1);
    chk("rest_state", bus.state_o, 4);
    chk("rest_level", bus.level_o, 10);
    repeat (9) tick;
    chk("rel_9_level", bus.level_o, 1);
    chk("rel_9_state", bus.state_o, 4);
    tick;
    chk("rel_done_level", bus.level_o, 0);
    chk("rel_done_state", bus.state_o, 0);
    cnt = 0;
    repeat (20) begin tick; cnt += int'(bus.sound_o); end
    chk("idle_silent", cnt, 0);
    strobe(1'b0);
    repeat (30) tick;
    chk("atk2_max", bus.level_o, 15);
    repeat (16) tick;
    chk("sus2_state", bus.state_o, 3);
    strobe(1'b1);
    repeat (5) tick;
    chk("rel2_level5", bus.level_o, 5);
    strobe(1'b0);
    chk("retrig_state", bus.state_o, 1);
    chk("retrig_level", bus.level_o, 5);
    tick;
    chk("retrig_hold", bus.level_o, 5);
    tick;
    chk("retrig_inc", bus.level_o, 6);
    tick;
    strobe(1'b0);
    chk("discard_step", bus.level_o, 6);
    tick;
    chk("discard_hold", bus.level_o, 6);
    tick;
    chk("discard_inc", bus.level_o, 7);
    repeat (10) tick;
    chk("prio_pre_level", bus.level_o, 12);
    bus.enable_i = 1'b0;
    strobe(1'b0);
    chk("prio_state", bus.state_o, 4);
    chk("prio_level", bus.level_o, 12);
    chk("prio_sound", bus.sound_o, 0);
    cnt = 0;
    repeat (12) begin tick; cnt += int'(bus.sound_o); end
    chk("dis_silent", cnt, 0);
    chk("dis_level", bus.level_o, 0);
    chk("dis_state", bus.state_o, 0);
    strobe(1'b0);
    chk("dis_strobe_ignored", bus.state_o, 0);
    bus.enable_i = 1'b1;
    strobe(1'b0);
    repeat (14) tick;
    chk("rst_pre_level", bus.level_o, 7);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("midrst_level", bus.level_o, 0);
    chk("midrst_state", bus.state_o, 0);
    chk("midrst_sound", bus.sound_o, 0);
    tick;
    chk("midrst_stay", bus.state_o, 0);
    strobe(1'b0);
    chk("restart_state", bus.state_o, 1);
    chk("restart_level", bus.level_o, 0);
    repeat (2) tick;
    chk("restart_inc", bus.level_o, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
